// File: rtl/sdpbram_ext.sv
// Simple dual-port RAM with byte enables, self-clearing init sequence
// and a 1- or 2-cycle registered read path with optional write bypass.
module sdpbram_ext #(
   parameter int U_DLY  = 1,
   parameter int DW     = 16,
   parameter int DEPTH  = 10,
   parameter int RD_LAT = 1,
   parameter int BYPASS = 1
) (
   input  logic               clk_sys,
   input  logic               rst_n,
   input  logic               clr_req,
   output logic               init_busy,
   input  logic               wr_en,
   input  logic [DW/8-1:0]    wr_be,
   input  logic [DEPTH-1:0]   wr_addr,
   input  logic [DW-1:0]      wr_data,
   input  logic               rd_en,
   input  logic [DEPTH-1:0]   rd_addr,
   output logic [DW-1:0]      rd_data,
   output logic               rd_vld
);

   localparam int MEM_DEPTH = 1 << DEPTH;
   localparam int NB        = DW / 8;

   // Register updates are zero-delay here; U_DLY only takes part in the
   // parameter sanity check so existing instantiations keep working.
   if ((DW % 8 != 0) || (DW < 8) || (RD_LAT != 1 && RD_LAT != 2) ||
       (U_DLY < 0)) begin : g_bad_param
      $error("sdpbram_ext: illegal parameter combination");
   end

   typedef enum logic {
      ST_CLEAR,
      ST_IDLE
   } state_t;

   state_t           state_q, state_d;
   logic [DEPTH-1:0] clr_addr_q, clr_addr_d;
   logic [DW-1:0]    mem_q [MEM_DEPTH];

   logic             idle;
   logic             rd_acc;
   logic [DW-1:0]    rd_word;
   logic             out_vld;
   logic [DW-1:0]    out_word;
   logic             rd_vld_q, rd_vld_d;
   logic [DW-1:0]    rd_data_q, rd_data_d;

   assign idle      = (state_q == ST_IDLE);
   assign init_busy = ~idle;
   assign rd_acc    = idle & rd_en;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      unique case (state_q)
         ST_CLEAR: begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == {DEPTH{1'b1}}) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (clr_req) begin
               state_d    = ST_CLEAR;
               clr_addr_d = '0;
            end
         end
         default: begin
            state_d    = ST_CLEAR;
            clr_addr_d = '0;
         end
      endcase
   end

   // Storage is never reset; only the clear walk zeroes it.
   always_ff @(posedge clk_sys) begin
      if (!idle) begin
         mem_q[clr_addr_q] <= '0;
      end else if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
               mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      rd_word = mem_q[rd_addr];
      if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr)) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
               rd_word[8*b +: 8] = wr_data[8*b +: 8];
            end
         end
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic          s1_vld_q;
      logic [DW-1:0] s1_data_q;

      always_ff @(posedge clk_sys or negedge rst_n) begin
         if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
         end else begin
            s1_vld_q <= rd_acc;
            if (rd_acc) begin
               s1_data_q <= rd_word;
            end
         end
      end

      assign out_vld  = s1_vld_q;
      assign out_word = s1_data_q;
   end else begin : g_lat1
      assign out_vld  = rd_acc;
      assign out_word = rd_word;
   end

   always_comb begin
      rd_vld_d  = out_vld;
      rd_data_d = rd_data_q;
      if (out_vld) begin
         rd_data_d = out_word;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_vld_q  <= rd_vld_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_vld  = rd_vld_q;
   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_sdpbram_ext.sv
// Directed bench for sdpbram_ext: a read-first/1-cycle instance and a
// write-first/2-cycle instance share stimulus; results go via scoreboards.
module tb_sdpbram_ext;

   logic        clk_sys;
   logic        rst_n;
   logic        clr_req;
   logic        wr_en;
   logic [1:0]  wr_be;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        rd_en;
   logic [3:0]  rd_addr;

   logic        busy_a, busy_b;
   logic        vld_a, vld_b;
   logic [15:0] data_a, data_b;

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   exp_t        qa[$];
   exp_t        qb[$];
   logic [15:0] model [16];
   int          cyc;
   int          checks;
   int          errors;

   sdpbram_ext #(
      .U_DLY(1), .DW(16), .DEPTH(4), .RD_LAT(1), .BYPASS(0)
   ) u_a (
      .clk_sys(clk_sys), .rst_n(rst_n), .clr_req(clr_req),
      .init_busy(busy_a), .wr_en(wr_en), .wr_be(wr_be),
      .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(data_a), .rd_vld(vld_a)
   );

   sdpbram_ext #(
      .U_DLY(1), .DW(16), .DEPTH(4), .RD_LAT(2), .BYPASS(1)
   ) u_b (
      .clk_sys(clk_sys), .rst_n(rst_n), .clr_req(clr_req),
      .init_busy(busy_b), .wr_en(wr_en), .wr_be(wr_be),
      .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(data_b), .rd_vld(vld_b)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   initial cyc = 0;
   always @(posedge clk_sys) cyc = cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] merge(input logic [15:0] old,
                                         input logic [15:0] nw,
                                         input logic [1:0]  be);
      logic [15:0] r;
      r = old;
      if (be[0]) r[7:0] = nw[7:0];
      if (be[1]) r[15:8] = nw[15:8];
      return r;
   endfunction

   always @(negedge clk_sys) begin
      exp_t e;
      if (qa.size() > 0 && qa[0].due < cyc) begin
         e = qa.pop_front();
         chk("a_missing_result", 32'(cyc), 32'(e.due));
      end
      if (vld_a) begin
         if (qa.size() == 0) begin
            chk("a_spurious_vld", 32'(vld_a), 32'd0);
         end else begin
            e = qa.pop_front();
            chk("a_rd_data", 32'(data_a), 32'(e.data));
            chk("a_rd_latency", 32'(cyc), 32'(e.due));
         end
      end
   end

   always @(negedge clk_sys) begin
      exp_t e;
      if (qb.size() > 0 && qb[0].due < cyc) begin
         e = qb.pop_front();
         chk("b_missing_result", 32'(cyc), 32'(e.due));
      end
      if (vld_b) begin
         if (qb.size() == 0) begin
            chk("b_spurious_vld", 32'(vld_b), 32'd0);
         end else begin
            e = qb.pop_front();
            chk("b_rd_data", 32'(data_b), 32'(e.data));
            chk("b_rd_latency", 32'(cyc), 32'(e.due));
         end
      end
   end

   // One clock of stimulus; idle says whether the bench expects the
   // controller to accept accesses in this cycle.
   task automatic step(input logic we, input logic [1:0] be,
                       input logic [3:0] wa, input logic [15:0] wd,
                       input logic re, input logic [3:0] ra,
                       input logic clr, input bit idle);
      exp_t ea, eb;
      chk("busy_a", 32'(busy_a), 32'(!idle));
      chk("busy_b", 32'(busy_b), 32'(!idle));
      wr_en   = we;
      wr_be   = be;
      wr_addr = wa;
      wr_data = wd;
      rd_en   = re;
      rd_addr = ra;
      clr_req = clr;
      if (idle) begin
         if (re) begin
            ea.data = model[ra];
            ea.due  = cyc + 1;
            eb.data = (we && wa == ra) ? merge(model[ra], wd, be)
                                       : model[ra];
            eb.due  = cyc + 2;
            qa.push_back(ea);
            qb.push_back(eb);
         end
         if (we) model[wa] = merge(model[wa], wd, be);
         if (clr) begin
            for (int i = 0; i < 16; i++) model[i] = 16'h0000;
         end
      end
      @(negedge clk_sys);
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_busy_a"}, 32'(busy_a), 32'd1);
      chk({tag, "_busy_b"}, 32'(busy_b), 32'd1);
      chk({tag, "_vld_a"}, 32'(vld_a), 32'd0);
      chk({tag, "_vld_b"}, 32'(vld_b), 32'd0);
      chk({tag, "_data_a"}, 32'(data_a), 32'd0);
      chk({tag, "_data_b"}, 32'(data_b), 32'd0);
   endtask

   // Counts busy cycles from the current falling edge while hammering
   // both ports; every such access must be dropped.
   task automatic count_busy(input string tag);
      int n;
      n = 0;
      while (busy_a && n < 40) begin
         chk({tag, "_busy_b"}, 32'(busy_b), 32'd1);
         chk({tag, "_vld_a"}, 32'(vld_a), 32'd0);
         chk({tag, "_vld_b"}, 32'(vld_b), 32'd0);
         wr_en   = 1'b1;
         wr_be   = 2'b11;
         wr_addr = 4'(n);
         wr_data = 16'hFFFF;
         rd_en   = 1'b1;
         rd_addr = 4'(n);
         n++;
         @(negedge clk_sys);
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk({tag, "_len"}, 32'(n), 32'd16);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      clr_req = 1'b0;
      wr_en   = 1'b0;
      wr_be   = 2'b00;
      wr_addr = 4'h0;
      wr_data = 16'h0000;
      rd_en   = 1'b0;
      rd_addr = 4'h0;
      for (int i = 0; i < 16; i++) model[i] = 16'h0000;

      repeat (3) @(negedge clk_sys);
      rst_chk("por");
      rst_n = 1'b1;
      count_busy("por_busy");

      for (int i = 0; i < 16; i++) step(0, 2'b00, 0, 0, 1, 4'(i), 0, 1);
      nop(3);

      step(1, 2'b11, 4'h3, 16'hA5A5, 0, 0, 0, 1);
      step(1, 2'b01, 4'h3, 16'h1234, 0, 0, 0, 1);
      step(0, 2'b00, 0, 0, 1, 4'h3, 0, 1);
      nop(3);

      step(1, 2'b11, 4'h5, 16'h1111, 0, 0, 0, 1);
      step(1, 2'b11, 4'h5, 16'hBEEF, 1, 4'h5, 0, 1);
      step(0, 2'b00, 0, 0, 1, 4'h5, 0, 1);
      step(1, 2'b00, 4'h5, 16'hFFFF, 0, 0, 0, 1);
      step(0, 2'b00, 0, 0, 1, 4'h5, 0, 1);
      step(1, 2'b01, 4'h5, 16'h00CC, 1, 4'h5, 0, 1);
      step(1, 2'b10, 4'h6, 16'h7700, 1, 4'h5, 0, 1);
      step(1, 2'b11, 4'h5, 16'h0101, 1, 4'h6, 0, 1);
      step(0, 2'b00, 0, 0, 1, 4'h5, 0, 1);
      nop(3);

      for (int i = 0; i < 4; i++)
         step(1, 2'b11, 4'(i), 16'h0010 + 16'(i), 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 2'b00, 0, 0, 1, 4'(i), 0, 1);
      nop(3);

      for (int i = 0; i < 16; i++)
         step(1, 2'b11, 4'(i), 16'h1000 + 16'(i * 17), 0, 0, 0, 1);
      step(1, 2'b11, 4'hE, 16'hDEAD, 1, 4'h2, 1, 1);
      for (int i = 0; i < 16; i++)
         step(1, 2'b11, 4'(i), 16'hCAFE, 1, 4'(i), (i == 8), 0);
      for (int i = 0; i < 16; i++) step(0, 2'b00, 0, 0, 1, 4'(i), 0, 1);
      nop(3);

      step(1, 2'b11, 4'hC, 16'h7777, 0, 0, 0, 1);
      step(0, 2'b00, 0, 0, 1, 4'hC, 0, 1);
      nop(3);
      step(0, 2'b00, 0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 7; i++) step(0, 2'b00, 0, 0, 1, 4'(i), 0, 0);
      rst_n = 1'b0;
      clr_req = 1'b0;
      rd_en = 1'b0;
      #1;
      rst_chk("midclr_rst");
      @(negedge clk_sys);
      @(negedge clk_sys);
      rst_n = 1'b1;
      count_busy("midclr_busy");
      step(0, 2'b00, 0, 0, 1, 4'hC, 0, 1);
      nop(3);

      step(1, 2'b11, 4'h9, 16'h4242, 0, 0, 0, 1);
      step(0, 2'b00, 0, 0, 1, 4'h9, 0, 1);
      rd_en = 1'b0;
      #2;
      rst_n = 1'b0;
      qb.delete();
      for (int i = 0; i < 16; i++) model[i] = 16'h0000;
      #1;
      rst_chk("midrd_rst");
      @(negedge clk_sys);
      @(negedge clk_sys);
      rst_n = 1'b1;
      count_busy("midrd_busy");
      step(0, 2'b00, 0, 0, 1, 4'h9, 0, 1);
      step(0, 2'b00, 0, 0, 1, 4'h5, 0, 1);
      nop(4);

      chk("qa_drained", 32'(qa.size()), 32'd0);
      chk("qb_drained", 32'(qb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sdpbram_ext.md
SDPBRAM_EXT -- requirements
Module: sdpbram_ext

Interface
REQ-001 The block SHALL have parameter U_DLY, default 1, meaning the simulation delay on every register assignment.
REQ-002 The block SHALL have parameter DW, default 16, meaning the data width; it must be a multiple of 8.
REQ-003 The block SHALL have parameter DEPTH, default 10, meaning the address width, giving MEM_DEPTH = 2^DEPTH words.
REQ-004 The block SHALL have parameter RD_LAT, default 1, meaning the read latency; legal values are 1 and 2.
REQ-005 The block SHALL have parameter BYPASS, default 1, meaning the read-during-write mode: 1 = write-first, 0 = read-first.
REQ-006 Port clk_sys  input  1  system clock; all logic is rising-edge.
REQ-007 Port rst_n  input  1  asynchronous active-low reset.
REQ-008 Port clr_req  input  1  single-cycle pulse requesting a full memory clear.
REQ-009 Port init_busy  output  1  high while the clear sequence runs.
REQ-010 Port wr_en  input  1  write strobe.
REQ-011 Port wr_be  input  DW/8  byte enables; bit i covers data bits [8i+7:8i].
REQ-012 Port wr_addr  input  DEPTH  write address.
REQ-013 Port wr_data  input  DW  write data.
REQ-014 Port rd_en  input  1  read strobe.
REQ-015 Port rd_addr  input  DEPTH  read address.
REQ-016 Port rd_data  output  DW  read data, registered.
REQ-017 Port rd_vld  output  1  one-cycle pulse marking valid rd_data.

Function
REQ-018 The controller SHALL be a two-state FSM, CLEAR and IDLE, with a DEPTH-bit clear address counter.
REQ-019 In CLEAR, one word per clock SHALL be written to all-zeros, starting at address 0 and incrementing.
REQ-020 CLEAR SHALL go to IDLE on the edge that writes address MEM_DEPTH-1, so init_busy is high for exactly MEM_DEPTH cycles.
REQ-021 IDLE SHALL go to CLEAR when clr_req=1; the counter restarts at 0.
REQ-022 clr_req SHALL be ignored while in CLEAR.
REQ-023 While init_busy=1, wr_en and rd_en SHALL be ignored and rd_vld SHALL stay 0.
REQ-024 In IDLE, when wr_en=1, only the bytes of mem[wr_addr] whose wr_be bit is 1 SHALL be updated.
REQ-025 wr_be all-zero with wr_en=1 SHALL leave memory unchanged.
REQ-026 In IDLE, rd_en sampled at edge N SHALL produce rd_data and rd_vld=1 at edge N+RD_LAT-1+1, i.e. 1 cycle for RD_LAT=1 and 2 cycles for RD_LAT=2.
REQ-027 With RD_LAT=2, back-to-back reads SHALL be fully pipelined: one result per cycle.
REQ-028 rd_data SHALL hold its last value when no read completes.
REQ-029 rd_vld SHALL be 0 in every cycle where no read completes.
REQ-030 On a same-cycle read and write to the same address with BYPASS=1, rd_data SHALL be the old word merged bytewise with wr_data under wr_be.
REQ-031 On the same collision with BYPASS=0, rd_data SHALL be the old word.
REQ-032 Simultaneous reads and writes to different addresses SHALL not interact.
REQ-033 Addresses SHALL be used modulo MEM_DEPTH, with no out-of-range handling.
REQ-034 A clr_req in the same cycle as wr_en/rd_en in IDLE SHALL let that access complete, and the clear SHALL start on the next cycle.

Reset
REQ-035 During rst_n=0, the FSM SHALL be in CLEAR, the counter 0, init_busy=1, rd_data=0, rd_vld=0, and pipeline valid bits 0.
REQ-036 After rst_n deasserts, a clear SHALL run automatically.
REQ-037 A reset asserted mid-clear or mid-read SHALL discard in-flight reads and restart the clear from address 0.
REQ-038 Memory contents SHALL not be reset asynchronously; only the clear sequence zeroes them.

Verification (DW=16, DEPTH=4, MEM_DEPTH=16)
REQ-039 Release reset, then read every address once init_busy falls -> init_busy is high exactly 16 cycles, and every read returns 0x0000 with rd_vld.
REQ-040 Write 0xA5A5 to addr 3 with wr_be=11, then write 0x1234 with wr_be=01, then read addr 3 -> rd_data=0xA534; with RD_LAT=2, rd_vld appears 2 cycles after rd_en.
REQ-041 Same-cycle write of 0xBEEF (wr_be=11) and read of addr 5, which holds 0x1111 -> BYPASS=1 returns 0xBEEF and BYPASS=0 returns 0x1111; a following read returns 0xBEEF in both modes.
REQ-042 Pulse clr_req after filling memory, and drive wr_en during the busy window -> the busy writes are dropped, and all addresses read 0x0000 afterwards.
REQ-043 Assert rst_n=0 at clear address 7, then release -> the clear restarts at 0, init_busy stays high for 16 cycles, and rd_vld is 0 throughout.
REQ-044 With RD_LAT=2, issue 4 back-to-back reads of addrs 0..3 holding 0x0010..0x0013 -> 4 consecutive rd_vld pulses carrying 0x0010..0x0013 in order.
